// File: rtl/game_scheduler.sv
// game_scheduler: runs a table of counter-game scenarios through one game instance and records outcomes
// Ports: clk, rst_l (sync, active low); cfg_we/cfg_addr/cfg_control/cfg_ivalue write the scenario table;
// num_scen/start/abort control a run; game_reset/control/i_value/INIT drive the game, who/gameover come back;
// busy/done/cur_idx report progress; res_addr/res_data read results; win/lose/tout_total count outcomes.
module game_scheduler #(
   parameter int COUNTER_SIZE = 4,
   parameter int RESET_CYCLES = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    rst_l,
   input  logic                    cfg_we,
   input  logic [3:0]              cfg_addr,
   input  logic [1:0]              cfg_control,
   input  logic [COUNTER_SIZE-1:0] cfg_ivalue,
   input  logic [4:0]              num_scen,
   input  logic                    start,
   input  logic                    abort,
   output logic                    game_reset,
   output logic [1:0]              control,
   output logic [COUNTER_SIZE-1:0] i_value,
   output logic                    INIT,
   input  logic [1:0]              who,
   input  logic                    gameover,
   output logic                    busy,
   output logic                    done,
   output logic [3:0]              cur_idx,
   input  logic [3:0]              res_addr,
   output logic [1:0]              res_data,
   output logic [4:0]              win_total,
   output logic [4:0]              lose_total,
   output logic [4:0]              tout_total
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(RESET_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, LOAD, INIT_S, RUN, RECORD} state_t;
   state_t state, nxt;
   logic [1:0] tbl_ctl [16];
   logic [COUNTER_SIZE-1:0] tbl_val [16];
   logic [1:0] res [16];
   logic [4:0] n;
   logic [RW-1:0] rcnt;
   logic [TW-1:0] timer;
   logic [1:0] outc;
   logic fin, done_r, go, last, tmo;
   // fin keeps busy high during the done cycle so a start there is ignored
   assign go = !busy && start && !abort;
   assign last = {1'b0, cur_idx} == n - 5'd1;
   assign tmo = timer == TW'(TIMEOUT - 1);
   always_ff @(posedge clk)
      if (!rst_l) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:   nxt = go && num_scen != 5'd0 ? LOAD : IDLE;
         LOAD:   nxt = rcnt == RW'(RESET_CYCLES - 1) ? INIT_S : LOAD;
         INIT_S: nxt = RUN;
         RUN:    nxt = gameover || tmo ? RECORD : RUN;
         RECORD: nxt = last ? IDLE : LOAD;
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end
   always_comb begin
      game_reset = state == IDLE || state == LOAD;
      INIT = state == INIT_S;
      busy = state != IDLE || fin;
      done = done_r;
      control = state == IDLE ? 2'd0 : tbl_ctl[cur_idx];
      i_value = state == IDLE ? '0 : tbl_val[cur_idx];
      res_data = res[res_addr];
   end
   always_ff @(posedge clk) begin
      if (cfg_we && !busy) begin
         tbl_ctl[cfg_addr] <= cfg_control;
         tbl_val[cfg_addr] <= cfg_ivalue;
      end
      if (!rst_l) begin
         cur_idx <= '0;
         n <= '0;
         rcnt <= '0;
         timer <= '0;
         outc <= '0;
         fin <= 1'b0;
         done_r <= 1'b0;
         win_total <= '0;
         lose_total <= '0;
         tout_total <= '0;
         for (int i = 0; i < 16; i++) res[i] <= 2'b00;
      end else begin
         fin <= state == RECORD && last && !abort;
         done_r <= (state == RECORD && last && !abort) || (go && num_scen == 5'd0);
         rcnt <= state == LOAD ? rcnt + 1'b1 : '0;
         timer <= state == RUN ? timer + 1'b1 : '0;
         // an unknown winner code is recorded the same as a timeout
         if (state == RUN)
            outc <= !gameover ? 2'b11 : who == 2'b10 ? 2'b10 : who == 2'b01 ? 2'b01 : 2'b11;
         if (go) begin
            cur_idx <= '0;
            n <= num_scen > 5'd16 ? 5'd16 : num_scen;
            win_total <= '0;
            lose_total <= '0;
            tout_total <= '0;
            for (int i = 0; i < 16; i++) res[i] <= 2'b00;
         end
         if (state == RECORD) begin
            res[cur_idx] <= outc;
            if (outc == 2'b10 && win_total != 5'd16) win_total <= win_total + 5'd1;
            if (outc == 2'b01 && lose_total != 5'd16) lose_total <= lose_total + 5'd1;
            if (outc == 2'b11 && tout_total != 5'd16) tout_total <= tout_total + 5'd1;
            if (!last && !abort) cur_idx <= cur_idx + 4'd1;
         end
      end
   end
endmodule
